pe_cycle_nctx: RTL and testbench
================================

# pe_cycle_nctx

Parametrised cycle-only processing-element model with NCTX independent job contexts, generalising the two-context cycle PE. It sits at a router's local port, absorbing input flits into a free context, modelling a fixed compute latency, and returning result packets on a per-context virtual channel. Output ownership is round-robin and packet-atomic. No real arithmetic is modelled beyond a checksum used for traceability.

## Interface
- NCTX, 4: number of job contexts (2..8)
- DATAW, 31: flit MSB index; flit width is DATAW+1
- NVC, 2: number of virtual channels
- VCHW, 0: ovch MSB index, equal to clog2(NVC)-1
- NIN, 4: input flits per job (2..16)
- NOUT, 2: output flits per result packet (1..16)
- MAC_CYC, 8: compute cycles per job (1..255)
- clk  in  1  clock
- rst_  in  1  reset; one clock, synchronous, active-high
- idata  in  DATAW+1  input flit from router
- ivalid  in  1  idata valid
- irdy  in  NVC  per-VC credit/ready from router
- odata  out  DATAW+1  output flit
- ovalid  out  1  odata valid
- ovch  out  VCHW+1  VC of odata
- idrop  out  1  one-cycle pulse: valid flit discarded, no free context
- busy  out  NCTX  per-context "not IDLE"

## Operation
- Context c has fixed VC c mod NVC. It keeps state, an 8-bit cycle counter, a 4-bit flit counter and a DATAW+1 sum.
- Context states:
  - IDLE: goes to RECV on its first accepted flit.
  - RECV: collects NIN flits, then goes to MAC.
  - MAC: counts MAC_CYC cycles, then goes to SEND.
  - SEND: emits NOUT flits, then returns to IDLE.
- Sum: wrapping add of every received flit. It clears when the context enters RECV.
- Input dispatch:
  - The current owner is held while it is in RECV.
  - With no owner, the lowest-index IDLE context takes the flit.
  - If no context is IDLE, the flit is dropped and idrop=1 that cycle.
- Output arbitration:
  - Requesters are SEND contexts whose irdy bit is 1.
  - The winner is chosen round-robin, starting one index after the last winner. Last-winner pointer reset value is NCTX-1.
  - The winner owns the output until its NOUT-th flit has been sent.
  - If the owner's irdy bit is 0, it stalls (no flit) but keeps ownership.
- Output flit k (k=0..NOUT-1) = sum + k, with wrapping add.

## Timing
- Reset: all contexts IDLE, counters and sums 0, no owners, ovalid=0, odata=0, ovch=0, idrop=0, busy=0.
- Reset asserted mid-job aborts every job. Flits presented during reset are ignored and are not counted as drops.
- Accepting flit NIN moves the context to MAC on the next edge.
- MAC lasts exactly MAC_CYC cycles.
- The first SEND cycle can win arbitration. ovalid is registered, so the first output flit appears 1 cycle after the grant.
- Zero-load latency (last input flit accepted to first ovalid) = MAC_CYC+2 cycles.
- Flit send condition: owner holds the output and irdy[vc] is sampled 1 in the cycle before ovalid.
- Leaving SEND after the NOUT-th flit returns the context to IDLE on the next edge. It can accept a new flit that same cycle.
- Another context may win arbitration in the cycle right after the last flit, so back-to-back packets have no bubble.
- Same-cycle events:
  - A context leaving SEND→IDLE while a new flit arrives takes the flit only if it is the lowest-index IDLE context after the update. Dispatch uses registered state, so the freed context is usable one cycle later.
  - All contexts busy with ivalid=1: drop the flit, no state change.
- Counters wrap nowhere: they are bounded by the parameters.

## Structure
- Shared package/defines hold:
  - state encodings IDLE=2'b00, RECV=2'b01, MAC=2'b10, SEND=2'b11
  - Enable_-style reset constant
  - clog2 helper
- One sub-module, pe_ctx_fsm, instantiated NCTX times. It contains the per-context state, counters and sum, plus req/grt/stall ports.
- Top level holds:
  - input dispatch
  - round-robin output arbiter with ownership hold
  - registered output mux
  - idrop and busy

## Test plan
- NCTX=4, MAC_CYC=8, one job, flits 1,2,3,4 with irdy=2'b11 -> ctx0 busy. Output flits 10 then 11 on ovch=0. First ovalid 10 cycles after flit 4.
- Four jobs back-to-back, irdy all 1 -> contexts 0..3 filled in order. Packets leave round-robin 0,1,2,3 with no idle cycle between packets.
- A fifth job while all four contexts are busy -> idrop pulses once per flit; no context state changes.
- irdy[1]=0 while ctx1 owns the output mid-packet -> ovalid=0 during the stall, ctx3 is not granted, and the packet resumes with the correct k when irdy[1]=1.
- rst_ asserted for 1 cycle during ctx0 MAC and ctx1 RECV -> next cycle all outputs 0 and busy=0. A fresh job then completes normally.
- NIN=2, NOUT=1, MAC_CYC=1, flits 0xFFFFFFFF and 0x2 -> single output flit 0x1 (wrap).

Source files
------------

// File: rtl/pe_cycle_nctx_pkg.sv
// rtl/pe_cycle_nctx_pkg.sv - shared types and constants for the multi-context cycle PE
// Purpose: context state encoding, reset polarity constant and a clog2 helper.
// Ports: none (package).
package pe_cycle_nctx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RECV = 2'b01,
    ST_MAC  = 2'b10,
    ST_SEND = 2'b11
  } ctx_state_e;

  // Reset is asserted when rst_ equals this value.
  localparam logic RST_ACTIVE = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_ctx_fsm.sv
// rtl/pe_ctx_fsm.sv - one job context: receive, compute delay, send
// Purpose: per-context state, 8-bit cycle counter, 4-bit flit counter and running sum.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   acc_i, data_i  flit accepted by this context this cycle, and its data
//   irdy_i         credit of this context's VC
//   grt_i          this context sends a flit this cycle
//   state_o        current state
//   sum_o, kcnt_o  running sum and current flit index (output index while sending)
//   last_o         current output flit is the final one of the packet
//   req_o, stall_o sending and VC ready / sending and VC blocked
module pe_ctx_fsm
  import pe_cycle_nctx_pkg::*;
#(
  parameter int DATAW   = 31,
  parameter int NIN     = 4,
  parameter int NOUT    = 2,
  parameter int MAC_CYC = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             acc_i,
  input  logic [DATAW:0]   data_i,
  input  logic             irdy_i,
  input  logic             grt_i,
  output ctx_state_e       state_o,
  output logic [DATAW:0]   sum_o,
  output logic [3:0]       kcnt_o,
  output logic             last_o,
  output logic             req_o,
  output logic             stall_o
);

  localparam logic [3:0] NIN_LAST  = 4'(NIN - 1);
  localparam logic [3:0] NOUT_LAST = 4'(NOUT - 1);
  localparam logic [7:0] MAC_LAST  = 8'(MAC_CYC - 1);

  ctx_state_e     state_q;
  logic [7:0]     cyc_q;
  logic [3:0]     flit_q;   // input count in RECV, output index in SEND
  logic [DATAW:0] sum_q;

  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ACTIVE) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      flit_q  <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (acc_i) begin
          state_q <= ST_RECV;
          sum_q   <= data_i;        // sum restarts with the first flit
          flit_q  <= 4'd1;
        end
        ST_RECV: if (acc_i) begin
          sum_q <= sum_q + data_i;
          if (flit_q == NIN_LAST) begin
            state_q <= ST_MAC;
            flit_q  <= '0;
            cyc_q   <= '0;
          end else begin
            flit_q <= flit_q + 4'd1;
          end
        end
        ST_MAC: begin
          if (cyc_q == MAC_LAST) begin
            state_q <= ST_SEND;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q + 8'd1;
          end
        end
        ST_SEND: if (grt_i) begin
          if (flit_q == NOUT_LAST) begin
            state_q <= ST_IDLE;
            flit_q  <= '0;
          end else begin
            flit_q <= flit_q + 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign sum_o   = sum_q;
  assign kcnt_o  = flit_q;
  assign last_o  = (flit_q == NOUT_LAST);
  assign req_o   = (state_q == ST_SEND) && irdy_i;
  assign stall_o = (state_q == ST_SEND) && !irdy_i;

endmodule

// File: rtl/pe_cycle_nctx.sv
// rtl/pe_cycle_nctx.sv - cycle-only PE with NCTX job contexts behind a router local port
// Purpose: input dispatch to contexts, round-robin packet-atomic output arbitration,
//          registered output flit, drop and busy indication.
// Ports:
//   clk, rst_      clock, synchronous active-high reset
//   idata, ivalid  input flit from router
//   irdy           per-VC ready from router
//   odata, ovalid, ovch  registered output flit, valid and VC
//   idrop          flit discarded this cycle (no free context)
//   busy           per-context not-IDLE
module pe_cycle_nctx
  import pe_cycle_nctx_pkg::*;
#(
  parameter int NCTX    = 4,
  parameter int DATAW   = 31,
  parameter int NVC     = 2,
  parameter int VCHW    = 0,
  parameter int NIN     = 4,
  parameter int NOUT    = 2,
  parameter int MAC_CYC = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATAW:0]    idata,
  input  logic              ivalid,
  input  logic [NVC-1:0]    irdy,
  output logic [DATAW:0]    odata,
  output logic              ovalid,
  output logic [VCHW:0]     ovch,
  output logic              idrop,
  output logic [NCTX-1:0]   busy
);

  localparam int CW = clog2(NCTX);
  localparam int VW = VCHW + 1;
  localparam int FW = DATAW + 1;

  ctx_state_e     st   [NCTX];
  logic [DATAW:0] sum  [NCTX];
  logic [3:0]     kcnt [NCTX];
  logic [NCTX-1:0] acc, grt, req, stall, last;

  for (genvar c = 0; c < NCTX; c++) begin : g_ctx
    pe_ctx_fsm #(
      .DATAW(DATAW), .NIN(NIN), .NOUT(NOUT), .MAC_CYC(MAC_CYC)
    ) u_ctx (
      .clk_i   (clk),
      .rst_i   (rst_),
      .acc_i   (acc[c]),
      .data_i  (idata),
      .irdy_i  (irdy[c % NVC]),
      .grt_i   (grt[c]),
      .state_o (st[c]),
      .sum_o   (sum[c]),
      .kcnt_o  (kcnt[c]),
      .last_o  (last[c]),
      .req_o   (req[c]),
      .stall_o (stall[c])
    );
    assign busy[c] = (st[c] != ST_IDLE);
  end

  // Dispatch: a context in RECV keeps the input; otherwise the lowest IDLE one takes it.
  logic recv_found, idle_found;
  always_comb begin
    acc        = '0;
    recv_found = 1'b0;
    idle_found = 1'b0;
    for (int c = 0; c < NCTX; c++) begin
      if (st[c] == ST_RECV) begin
        recv_found = 1'b1;
        acc[c]     = ivalid;
      end
    end
    if (!recv_found) begin
      for (int c = 0; c < NCTX; c++) begin
        if (!idle_found && st[c] == ST_IDLE) begin
          idle_found = 1'b1;
          acc[c]     = ivalid;
        end
      end
    end
    idrop = ivalid && !recv_found && !idle_found && (rst_ != RST_ACTIVE);
  end

  // Output arbitration: the owner keeps the port for the whole packet; a free port
  // is granted round-robin and the grant cycle already sends flit 0.
  logic          own_v_q;
  logic [CW-1:0] own_q, last_q, win;
  logic          send, new_grant;
  int            idx;

  always_comb begin
    grt       = '0;
    win       = '0;
    send      = 1'b0;
    new_grant = 1'b0;
    idx       = 0;
    if (own_v_q) begin
      if (!stall[own_q]) begin
        send = 1'b1;
        win  = own_q;
      end
    end else begin
      for (int i = 1; i <= NCTX; i++) begin
        idx = (int'(last_q) + i) % NCTX;
        if (!new_grant && req[idx]) begin
          new_grant = 1'b1;
          win       = CW'(idx);
        end
      end
      send = new_grant;
    end
    if (send) grt[win] = 1'b1;
  end

  logic [DATAW:0] odata_q;
  logic           ovalid_q;
  logic [VCHW:0]  ovch_q;

  always_ff @(posedge clk) begin
    if (rst_ == RST_ACTIVE) begin
      own_v_q  <= 1'b0;
      own_q    <= '0;
      last_q   <= CW'(NCTX - 1);
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
    end else begin
      ovalid_q <= send;
      if (send) begin
        odata_q <= sum[win] + FW'(kcnt[win]);
        ovch_q  <= VW'(int'(win) % NVC);
        own_v_q <= !last[win];
        own_q   <= win;
      end
      if (new_grant) last_q <= win;
    end
  end

  assign odata  = odata_q;
  assign ovalid = ovalid_q;
  assign ovch   = ovch_q;

endmodule

// File: tb/tb_pe_cycle_nctx.sv
// tb/tb_pe_cycle_nctx.sv - directed self-checking bench for pe_cycle_nctx
module tb_pe_cycle_nctx;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_;
  logic [31:0] idata;
  logic        ivalid;
  logic [1:0]  irdy;
  logic [31:0] odata;
  logic        ovalid;
  logic [0:0]  ovch;
  logic        idrop;
  logic [3:0]  busy;

  logic [31:0] idata2;
  logic        ivalid2;
  logic [1:0]  irdy2;
  logic [31:0] odata2;
  logic        ovalid2;
  logic [0:0]  ovch2;
  logic        idrop2;
  logic [1:0]  busy2;

  int passes = 0;
  int checks = 0;

  pe_cycle_nctx #(
    .NCTX(4), .DATAW(31), .NVC(2), .VCHW(0), .NIN(4), .NOUT(2), .MAC_CYC(8)
  ) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .irdy(irdy),
    .odata(odata), .ovalid(ovalid), .ovch(ovch), .idrop(idrop), .busy(busy)
  );

  pe_cycle_nctx #(
    .NCTX(2), .DATAW(31), .NVC(2), .VCHW(0), .NIN(2), .NOUT(1), .MAC_CYC(1)
  ) dut2 (
    .clk(clk), .rst_(rst_), .idata(idata2), .ivalid(ivalid2), .irdy(irdy2),
    .odata(odata2), .ovalid(ovalid2), .ovch(ovch2), .idrop(idrop2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] d, input logic ch);
    chk($sformatf("%s_ovalid", tag), 32'(ovalid), 32'(v));
    if (v) begin
      chk($sformatf("%s_odata", tag), odata, d);
      chk($sformatf("%s_ovch", tag), 32'(ovch), 32'(ch));
    end
  endtask

  task automatic load_job(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
    ivalid = 1'b1;
    idata = a; step();
    idata = b; step();
    idata = c; step();
    idata = d; step();
    ivalid = 1'b0;
  endtask

  int expa [8] = '{10, 11, 20, 21, 30, 31, 40, 41};
  int echa [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

  initial begin
    rst_ = 1'b1; idata = '0; ivalid = 1'b0; irdy = 2'b00;
    idata2 = '0; ivalid2 = 1'b0; irdy2 = 2'b11;
    step(); step();
    chk("rst_ovalid", 32'(ovalid), 0);
    chk("rst_odata", odata, 0);
    chk("rst_ovch", 32'(ovch), 0);
    chk("rst_idrop", 32'(idrop), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_ = 1'b0;
    step();

    // Single job, zero-load latency MAC_CYC+2.
    irdy = 2'b11;
    load_job(1, 2, 3, 4);
    chk("t1_busy", 32'(busy), 32'h1);
    for (int i = 1; i <= 9; i++) begin
      chk($sformatf("t1_wait%0d", i), 32'(ovalid), 0);
      step();
    end
    expect_out("t1_f0", 1'b1, 10, 1'b0); step();
    expect_out("t1_f1", 1'b1, 11, 1'b0); step();
    expect_out("t1_end", 1'b0, 0, 1'b0);
    chk("t1_busy_end", 32'(busy), 0);

    // Reset during ctx0 MAC and ctx1 RECV.
    load_job(1, 1, 1, 1);
    ivalid = 1'b1; idata = 7; step(); step();
    ivalid = 1'b0;
    chk("r_busy_pre", 32'(busy), 32'h3);
    rst_ = 1'b1; ivalid = 1'b1; idata = 9;
    step();
    rst_ = 1'b0; ivalid = 1'b0;
    chk("r_ovalid", 32'(ovalid), 0);
    chk("r_odata", odata, 0);
    chk("r_ovch", 32'(ovch), 0);
    chk("r_idrop", 32'(idrop), 0);
    chk("r_busy", 32'(busy), 0);
    load_job(5, 5, 5, 5);
    chk("r_busy_job", 32'(busy), 32'h1);
    repeat (9) step();
    expect_out("r_f0", 1'b1, 20, 1'b0); step();
    expect_out("r_f1", 1'b1, 21, 1'b0); step();
    expect_out("r_end", 1'b0, 0, 1'b0);

    // Fresh arbiter pointer, then four contexts loaded with output blocked.
    rst_ = 1'b1; step(); rst_ = 1'b0;
    irdy = 2'b00;
    load_job(1, 2, 3, 4);    chk("a_busy0", 32'(busy), 32'h1);
    load_job(2, 4, 6, 8);    chk("a_busy1", 32'(busy), 32'h3);
    load_job(3, 6, 9, 12);   chk("a_busy2", 32'(busy), 32'h7);
    load_job(4, 8, 12, 16);  chk("a_busy3", 32'(busy), 32'hf);
    repeat (12) step();
    for (int i = 0; i < 4; i++) begin
      ivalid = 1'b1; idata = 32'(100 + i);
      #1 chk($sformatf("drop%0d", i), 32'(idrop), 1);
      step();
    end
    ivalid = 1'b0;
    #1 chk("drop_idle", 32'(idrop), 0);
    chk("drop_busy", 32'(busy), 32'hf);
    chk("drop_ovalid", 32'(ovalid), 0);
    irdy = 2'b11;
    for (int i = 0; i < 8; i++) begin
      step();
      expect_out($sformatf("a_f%0d", i), 1'b1, 32'(expa[i]), echa[i][0]);
    end
    step();
    expect_out("a_end", 1'b0, 0, 1'b0);
    chk("a_busy_end", 32'(busy), 0);

    // Stall of the owning context mid-packet.
    irdy = 2'b00;
    load_job(5, 6, 7, 8);
    load_job(10, 12, 14, 16);
    load_job(15, 18, 21, 24);
    load_job(20, 24, 28, 32);
    repeat (12) step();
    irdy = 2'b11;
    step(); expect_out("s_f0", 1'b1, 26, 1'b0);
    step(); expect_out("s_f1", 1'b1, 27, 1'b0);
    step(); expect_out("s_f2", 1'b1, 52, 1'b1);
    irdy = 2'b01;
    step(); expect_out("s_stall0", 1'b0, 0, 1'b0);
    step(); expect_out("s_stall1", 1'b0, 0, 1'b0);
    step(); expect_out("s_stall2", 1'b0, 0, 1'b0);
    irdy = 2'b11;
    step(); expect_out("s_f3", 1'b1, 53, 1'b1);
    step(); expect_out("s_f4", 1'b1, 78, 1'b0);
    step(); expect_out("s_f5", 1'b1, 79, 1'b0);
    step(); expect_out("s_f6", 1'b1, 104, 1'b1);
    step(); expect_out("s_f7", 1'b1, 105, 1'b1);
    step(); expect_out("s_end", 1'b0, 0, 1'b0);

    // Small configuration: checksum wraps.
    ivalid2 = 1'b1; idata2 = 32'hFFFF_FFFF; step();
    idata2 = 32'h2; step();
    ivalid2 = 1'b0;
    chk("w_wait1", 32'(ovalid2), 0); step();
    chk("w_wait2", 32'(ovalid2), 0); step();
    chk("w_ovalid", 32'(ovalid2), 1);
    chk("w_odata", odata2, 32'h1);
    chk("w_ovch", 32'(ovch2), 0);
    step();
    chk("w_end", 32'(ovalid2), 0);
    chk("w_busy", 32'(busy2), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
